// File: rtl/hex_scroll_ctrl_pkg.sv
// hex_scroll_pkg: shared definitions for the HEX3..HEX0 scrolling message controller.
//   GLYPH_W         glyph code width
//   glyph_t         glyph code type
//   ST_*            controller state encoding (IDLE/LOAD/SCROLL/HOLD)
//   GL_*            named glyph codes (5'h00-5'h0F are hex digits 0-F)
//   SEG_BLANK       all segments off (active-low)
// Optional feature macro used by the controller: HEX_SCROLL_DIR_EN.
package hex_scroll_pkg;

    localparam int GLYPH_W = 5;

    typedef logic [GLYPH_W-1:0] glyph_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SCROLL = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam glyph_t GL_BLANK = 5'h10;
    localparam glyph_t GL_DASH  = 5'h11;
    localparam glyph_t GL_H     = 5'h12;
    localparam glyph_t GL_L     = 5'h13;
    localparam glyph_t GL_P     = 5'h14;
    localparam glyph_t GL_U     = 5'h15;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// hex_scroll_ctrl_if: glyph write port (valid/ready).
//   wr_valid  host offers a glyph
//   wr_ready  controller can accept a glyph
//   wr_glyph  glyph code
//   wr_last   final glyph of the message
// Modports: master = host side, slave = controller side.
interface hex_scroll_ctrl_if;
    import hex_scroll_pkg::*;

    logic   wr_valid;
    logic   wr_ready;
    glyph_t wr_glyph;
    logic   wr_last;

    modport master (output wr_valid, output wr_glyph, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_glyph, input wr_last, output wr_ready);

endinterface

// File: rtl/hex_glyph_dec.sv
// hex_glyph_dec: combinational glyph code -> 7-segment pattern.
//   glyph  in  glyph code
//   seg    out segments {g,f,e,d,c,b,a}, active-low
// Unassigned codes decode as blank.
module hex_glyph_dec
    import hex_scroll_pkg::*;
(
    input  glyph_t     glyph,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (glyph)
            5'h00:   seg = 7'h40;
            5'h01:   seg = 7'h79;
            5'h02:   seg = 7'h24;
            5'h03:   seg = 7'h30;
            5'h04:   seg = 7'h19;
            5'h05:   seg = 7'h12;
            5'h06:   seg = 7'h02;
            5'h07:   seg = 7'h78;
            5'h08:   seg = 7'h00;
            5'h09:   seg = 7'h10;
            5'h0A:   seg = 7'h08;
            5'h0B:   seg = 7'h03;
            5'h0C:   seg = 7'h46;
            5'h0D:   seg = 7'h21;
            5'h0E:   seg = 7'h06;
            5'h0F:   seg = 7'h0E;
            GL_DASH: seg = 7'h3F;
            GL_H:    seg = 7'h09;
            GL_L:    seg = 7'h47;
            GL_P:    seg = 7'h0C;
            GL_U:    seg = 7'h41;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: loadable glyph buffer scrolled across HEX3..HEX0.
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear back to IDLE with an empty buffer
//   run          1 = scroll advances, 0 = freeze (HOLD)
//   dir          (only with HEX_SCROLL_DIR_EN) 0 = scroll left, 1 = scroll right
//   wr           glyph write port (slave side)
//   hex3..hex0   registered active-low segment patterns, hex3 leftmost
// Optional feature macro: HEX_SCROLL_DIR_EN adds the dir input.
//
// state  | meaning
// IDLE   | buffer empty, display blank, waiting for first glyph
// LOAD   | accepting further glyphs, display blank
// SCROLL | prescaler running, pos advances on each tick
// HOLD   | prescaler, pos and display frozen
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int STEP_HZ   = 4,
    parameter int MSG_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               run,
`ifdef HEX_SCROLL_DIR_EN
    input  logic               dir,
`endif
    hex_scroll_ctrl_if.slave   wr,
    output logic [6:0]         hex3,
    output logic [6:0]         hex2,
    output logic [6:0]         hex1,
    output logic [6:0]         hex0
);

    localparam int DIV   = CLK_HZ / STEP_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int LEN_W = $clog2(MSG_DEPTH + 1);
    localparam int POS_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MSG_DEPTH - 1);

    logic [1:0]       state_q;
    logic [LEN_W-1:0] len_q;
    logic [POS_W-1:0] pos_q;
    logic [CNT_W-1:0] cnt_q;
    glyph_t           buf_q [MSG_DEPTH];

    logic             accept;
    logic             tick;
    logic             show;
    logic [LEN_W-1:0] len_m1;
    logic [POS_W-1:0] idx0, idx1, idx2, idx3;
    logic [POS_W-1:0] pos_step;
    logic [6:0]       seg3, seg2, seg1, seg0;

    // Successor/predecessor within 0..len-1, wrapping by compare so no modulo is needed.
    function automatic logic [POS_W-1:0] idx_inc(input logic [POS_W-1:0] i,
                                                 input logic [LEN_W-1:0] last);
        return (LEN_W'(i) == last) ? '0 : i + POS_W'(1);
    endfunction

    function automatic logic [POS_W-1:0] idx_dec(input logic [POS_W-1:0] i,
                                                 input logic [LEN_W-1:0] last);
        return (i == '0) ? last[POS_W-1:0] : i - POS_W'(1);
    endfunction

    assign wr.wr_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign tick        = (state_q == ST_SCROLL) && run && (cnt_q == CNT_MAX);
    assign show        = (state_q == ST_SCROLL) || (state_q == ST_HOLD);
    assign len_m1      = len_q - LEN_W'(1);

    // Chained wrap handles len < 4, where the message repeats across the digits.
    assign idx0 = pos_q;
    assign idx1 = idx_inc(idx0, len_m1);
    assign idx2 = idx_inc(idx1, len_m1);
    assign idx3 = idx_inc(idx2, len_m1);

`ifdef HEX_SCROLL_DIR_EN
    assign pos_step = dir ? idx_dec(pos_q, len_m1) : idx1;
`else
    assign pos_step = idx1;
`endif

    hex_glyph_dec u_dec3 (.glyph(buf_q[idx0]), .seg(seg3));
    hex_glyph_dec u_dec2 (.glyph(buf_q[idx1]), .seg(seg2));
    hex_glyph_dec u_dec1 (.glyph(buf_q[idx2]), .seg(seg1));
    hex_glyph_dec u_dec0 (.glyph(buf_q[idx3]), .seg(seg0));

    // Buffer contents need no reset: len_q gates what is ever displayed.
    always_ff @(posedge clk) begin
        if (accept && !clr) begin
            buf_q[len_q[POS_W-1:0]] <= wr.wr_glyph;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            hex3    <= SEG_BLANK;
            hex2    <= SEG_BLANK;
            hex1    <= SEG_BLANK;
            hex0    <= SEG_BLANK;
        end else if (clr) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            hex3    <= SEG_BLANK;
            hex2    <= SEG_BLANK;
            hex1    <= SEG_BLANK;
            hex0    <= SEG_BLANK;
        end else begin
            hex3 <= show ? seg3 : SEG_BLANK;
            hex2 <= show ? seg2 : SEG_BLANK;
            hex1 <= show ? seg1 : SEG_BLANK;
            hex0 <= show ? seg0 : SEG_BLANK;
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        len_q <= len_q + LEN_W'(1);
                        // Filling the last entry ends the load even without wr_last.
                        if (wr.wr_last || (len_q == LAST_IDX)) begin
                            state_q <= ST_SCROLL;
                            pos_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_SCROLL: begin
                    if (!run) begin
                        state_q <= ST_HOLD;
                    end else if (tick) begin
                        cnt_q <= '0;
                        pos_q <= pos_step;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (run) begin
                        state_q <= ST_SCROLL;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
module tb_hex_scroll_ctrl;
    import hex_scroll_pkg::*;

    localparam int DIV   = 4;
    localparam int DEPTH = 16;

    // Reference-model phases.
    localparam int M_IDLE = 0, M_LOAD = 1, M_SCROLL = 2, M_HOLD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic run = 1'b0;
`ifdef HEX_SCROLL_DIR_EN
    logic dir = 1'b0;
`endif
    logic [6:0] hex3, hex2, hex1, hex0;

    hex_scroll_ctrl_if wr ();

    hex_scroll_ctrl #(.CLK_HZ(8), .STEP_HZ(2), .MSG_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .run   (run),
`ifdef HEX_SCROLL_DIR_EN
        .dir   (dir),
`endif
        .wr    (wr),
        .hex3  (hex3),
        .hex2  (hex2),
        .hex1  (hex1),
        .hex0  (hex0)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    logic [4:0] msg [DEPTH];

    function automatic logic [6:0] seg_of(input int g);
        case (g)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
           12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
           17: return 7'h3F; 18: return 7'h09; 19: return 7'h47; 20: return 7'h0C;
           21: return 7'h41;
           default: return 7'h7F;
        endcase
    endfunction

    // Behavioural model: buffer as an int array, display by modulo indexing.
    int         m_state, m_len, m_pos, m_cnt;
    int         m_buf [DEPTH];
    logic [6:0] m_hex [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_IDLE; m_len = 0; m_pos = 0; m_cnt = 0;
            for (int k = 0; k < 4; k++) m_hex[k] = 7'h7F;
        end else if (clr) begin
            m_state = M_IDLE; m_len = 0; m_pos = 0; m_cnt = 0;
            for (int k = 0; k < 4; k++) m_hex[k] = 7'h7F;
        end else begin
            // hex3 shows buf[pos], hex0 shows buf[pos+3]
            for (int k = 0; k < 4; k++)
                m_hex[3-k] = (m_state == M_SCROLL || m_state == M_HOLD)
                             ? seg_of(m_buf[(m_pos + k) % m_len]) : 7'h7F;
            if (m_state == M_IDLE || m_state == M_LOAD) begin
                if (wr.wr_valid) begin
                    m_buf[m_len] = int'(wr.wr_glyph);
                    m_len++;
                    if (wr.wr_last || m_len == DEPTH) begin
                        m_state = M_SCROLL; m_pos = 0; m_cnt = 0;
                    end else begin
                        m_state = M_LOAD;
                    end
                end
            end else if (m_state == M_SCROLL) begin
                if (!run) m_state = M_HOLD;
                else if (m_cnt == DIV - 1) begin
                    m_cnt = 0;
`ifdef HEX_SCROLL_DIR_EN
                    if (dir) m_pos = (m_pos == 0) ? m_len - 1 : m_pos - 1;
                    else     m_pos = (m_pos + 1) % m_len;
`else
                    m_pos = (m_pos + 1) % m_len;
`endif
                end else m_cnt++;
            end else if (run) begin
                m_state = M_SCROLL;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_ready;
            exp_ready = (m_state == M_IDLE || m_state == M_LOAD);
            vectors++;
            if (hex3 !== m_hex[3] || hex2 !== m_hex[2] || hex1 !== m_hex[1] ||
                hex0 !== m_hex[0] || wr.wr_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL cycle t=%0t got hex=%h,%h,%h,%h ready=%b want hex=%h,%h,%h,%h ready=%b",
                         $time, hex3, hex2, hex1, hex0, wr.wr_ready,
                         m_hex[3], m_hex[2], m_hex[1], m_hex[0], exp_ready);
            end
        end
    end

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
        chk({name, ".hex3"}, hex3, e3);
        chk({name, ".hex2"}, hex2, e2);
        chk({name, ".hex1"}, hex1, e1);
        chk({name, ".hex0"}, hex0, e0);
    endtask

    task automatic do_clear();
        wr.wr_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Ends on the falling edge right after the final accepting rising edge.
    task automatic load_msg(input int n, input bit with_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                wr.wr_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wr.wr_valid = 1'b1;
            wr.wr_glyph = msg[i];
            wr.wr_last  = with_last && (i == n - 1);
            @(negedge clk);
        end
        wr.wr_valid = 1'b0;
        wr.wr_last  = 1'b0;
    endtask

    task automatic load_0123();
        for (int i = 0; i < 4; i++) msg[i] = 5'(i);
        load_msg(4, 1'b1, 1'b0);
    endtask

    initial begin
        int n;
        bit wl;
        wr.wr_valid = 1'b0; wr.wr_glyph = '0; wr.wr_last = 1'b0;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.hex3", hex3, 7'h7F);
        chk("reset.ready", {6'b0, wr.wr_ready}, 7'd1);
        chk_en = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk_all("idle20", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        // Load 0,1,2,3 and watch it scroll
        run = 1'b1;
        load_0123();
        @(negedge clk);
        chk_all("frame0", 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000);
        repeat (4) @(negedge clk);
        chk("step1.hex3", hex3, 7'b1111001);
        chk("step1.hex0", hex0, 7'b1000000);
        repeat (12) @(negedge clk);
        chk_all("wrap", 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000);
        do_clear();

        // Short messages repeat across the digits
        msg[0] = 5'h01; msg[1] = 5'h02;
        load_msg(2, 1'b1, 1'b0);
        @(negedge clk);
        chk_all("len2", 7'h79, 7'h24, 7'h79, 7'h24);
        do_clear();
        msg[0] = GL_H;
        load_msg(1, 1'b1, 1'b0);
        @(negedge clk);
        chk_all("len1_H", 7'h09, 7'h09, 7'h09, 7'h09);
        do_clear();

        // Full buffer without wr_last
        for (int i = 0; i < DEPTH; i++) msg[i] = 5'($urandom_range(0, 31));
        load_msg(DEPTH, 1'b0, 1'b0);
        chk("full.ready", {6'b0, wr.wr_ready}, 7'd0);
        repeat (30) @(negedge clk);
        do_clear();

        // Freeze with prescaler at 2, resume two cycles from a step
        load_0123();
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        repeat (9) @(negedge clk);
        chk("hold.hex3", hex3, 7'h40);
        run = 1'b1;
        repeat (3) @(negedge clk);
        chk("resume_pre.hex3", hex3, 7'h40);
        @(negedge clk);
        chk("resume_step.hex3", hex3, 7'h79);
        do_clear();

        // clr on a tick cycle
        load_0123();
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk_all("clr_tick", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        chk("clr_tick.ready", {6'b0, wr.wr_ready}, 7'd1);
        msg[0] = GL_L;
        load_msg(1, 1'b1, 1'b0);
        @(negedge clk);
        chk_all("reload_L", 7'h47, 7'h47, 7'h47, 7'h47);

        // Async reset mid-scroll
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all("rst_mid", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

`ifdef HEX_SCROLL_DIR_EN
        dir = 1'b1;
        load_0123();
        repeat (5) @(negedge clk);
        chk("right.hex3", hex3, 7'h30);
        chk("right.hex2", hex2, 7'h40);
        dir = 1'b0;
        do_clear();
`endif

        // Randomized traffic against the model
        for (int it = 0; it < 25; it++) begin
            n  = $urandom_range(1, DEPTH);
            wl = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) msg[i] = 5'($urandom_range(0, 31));
            run = 1'b1;
            load_msg(n, wl, 1'b1);
            repeat ($urandom_range(20, 70)) begin
                @(negedge clk);
                if ($urandom_range(0, 5) == 0) run = ~run;
`ifdef HEX_SCROLL_DIR_EN
                dir = 1'($urandom_range(0, 1));
`endif
                wr.wr_valid = 1'($urandom_range(0, 1));
                wr.wr_glyph = 5'($urandom_range(0, 31));
                wr.wr_last  = 1'($urandom_range(0, 1));
                clr = ($urandom_range(0, 60) == 0);
            end
            clr = 1'b0;
            wr.wr_last = 1'b0;
            do_clear();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
